// File: rtl/matmul_sequencer.sv
// Valid/ready front-end for the NxN pipelined matrix multiplier: streams in A then B,
// holds them on the multiplier buses, waits out its latency, then streams C back out.
module matmul_sequencer #(
  parameter int N           = 4,
  parameter int WIDTH       = 16,
  parameter int PIPE_STAGES = 5
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [WIDTH-1:0]                     in_data,
  output logic [N-1:0][N-1:0][WIDTH-1:0]       mm_a,
  output logic [N-1:0][N-1:0][WIDTH-1:0]       mm_b,
  input  logic [N-1:0][N-1:0][2*WIDTH-1:0]     mm_c,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [2*WIDTH-1:0]                   out_data,
  output logic                                 out_last,
  output logic                                 busy
);

  localparam int NN    = N * N;
  localparam int IDX_W = (NN > 1) ? $clog2(NN) : 1;
  localparam int RC_W  = (N > 1) ? $clog2(N) : 1;
  localparam int LAT_W = $clog2(PIPE_STAGES + 2);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, COMPUTE, DRAIN} state_t;

  state_t                               state_q;
  logic [IDX_W-1:0]                     idx_q;
  logic [LAT_W-1:0]                     lat_q;
  logic [N-1:0][N-1:0][WIDTH-1:0]       a_q;
  logic [N-1:0][N-1:0][WIDTH-1:0]       b_q;
  logic [N-1:0][N-1:0][2*WIDTH-1:0]     c_buf_q;

  logic [RC_W-1:0] row;
  logic [RC_W-1:0] col;
  logic            idx_last;

  assign row      = RC_W'(idx_q / IDX_W'(N));
  assign col      = RC_W'(idx_q % IDX_W'(N));
  assign idx_last = (idx_q == IDX_W'(NN - 1));

  assign in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign busy      = (state_q == COMPUTE) || (state_q == DRAIN);
  assign out_valid = (state_q == DRAIN);
  assign out_data  = out_valid ? c_buf_q[row][col] : '0;
  assign out_last  = out_valid && idx_last;
  assign mm_a      = a_q;
  assign mm_b      = b_q;

  // NOTE: every register here, including the operand and result arrays, is reset;
  // a restarted job must never see a stale operand or forward a stale result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD_A;
      idx_q   <= '0;
      lat_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_buf_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every branch reads this cycle's state.
      case (state_q)
        LOAD_A: if (in_valid) begin
          a_q[row][col] <= in_data;
          if (idx_last) begin
            idx_q   <= '0;
            state_q <= LOAD_B;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        LOAD_B: if (in_valid) begin
          b_q[row][col] <= in_data;
          if (idx_last) begin
            idx_q   <= '0;
            lat_q   <= '0;
            state_q <= COMPUTE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        COMPUTE: begin
          // mm_c has settled one cycle before this snapshot edge.
          if (lat_q == LAT_W'(PIPE_STAGES + 1)) begin
            c_buf_q <= mm_c;
            state_q <= DRAIN;
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        DRAIN: if (out_ready) begin
          if (idx_last) begin
            idx_q   <= '0;
            state_q <= LOAD_A;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: state_q <= LOAD_A;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer with a behavioural pipelined multiplier model.
module tb_matmul_sequencer;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int PS = 5;

  typedef logic [N-1:0][N-1:0][W-1:0]   amat_t;
  typedef logic [N-1:0][N-1:0][2*W-1:0] cmat_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_data = '0;
  amat_t          mm_a;
  amat_t          mm_b;
  cmat_t          mm_c;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*W-1:0] out_data;
  logic           out_last;
  logic           busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int start_cyc   = 0;

  cmat_t pipe_q [PS+1];

  matmul_sequencer #(.N(N), .WIDTH(W), .PIPE_STAGES(PS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mm_a(mm_a), .mm_b(mm_b), .mm_c(mm_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic cmat_t ref_mul(input amat_t a, input amat_t b);
    cmat_t c;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        logic [2*W-1:0] acc;
        acc = '0;
        for (int k = 0; k < N; k++) acc = acc + (2*W)'(a[i][k]) * (2*W)'(b[k][j]);
        c[i][j] = acc;
      end
    return c;
  endfunction

  // Multiplier stand-in: result valid PS+1 edges after the operands change.
  always @(posedge clk) begin
    pipe_q[0] <= ref_mul(mm_a, mm_b);
    for (int k = 1; k <= PS; k++) pipe_q[k] <= pipe_q[k-1];
  end
  assign mm_c = pipe_q[PS];

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  // kind 0: A[i][j]=i+j, 1: identity, 2: 2*identity, 3: all 0xFFFF
  function automatic amat_t mk_op(input int kind);
    amat_t m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        case (kind)
          0:       m[i][j] = W'(i + j);
          1:       m[i][j] = (i == j) ? W'(1) : W'(0);
          2:       m[i][j] = (i == j) ? W'(2) : W'(0);
          default: m[i][j] = 16'hFFFF;
        endcase
    return m;
  endfunction

  // kind 0: i+j, 1: 2*(i+j), 2: all 0xFFF80004 (four 0xFFFE0001 summed mod 2^32)
  function automatic cmat_t mk_res(input int kind);
    cmat_t m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        case (kind)
          0:       m[i][j] = 32'(i + j);
          1:       m[i][j] = 32'(2 * (i + j));
          default: m[i][j] = 32'hFFF80004;
        endcase
    return m;
  endfunction

  task automatic load_mat(input amat_t m, input bit toggle, input bit mark_start);
    int   i = 0;
    int   guard = 0;
    bit   phase = 1'b0;
    logic rdy;
    while (i < N*N && guard < 200) begin
      in_valid = toggle ? ~phase : 1'b1;
      phase    = ~phase;
      in_data  = m[i/N][i%N];
      @(negedge clk);
      rdy = in_ready;
      if (mark_start && i == 0 && in_valid && rdy) start_cyc = cyc;
      @(posedge clk);
      #1;
      if (in_valid && rdy) i++;
      guard++;
    end
    in_valid = 1'b0;
    if (guard >= 200) chk("load_timeout", 256'(i), 256'(N*N));
  endtask

  task automatic drain(input cmat_t exp, input bit timed, input int stall_beat,
                       input bit hold_next, input logic [W-1:0] next_data);
    int b = 0;
    int guard = 0;
    int stall_left = 3;
    while (b < N*N && guard < 300) begin
      if (hold_next) begin
        in_valid = 1'b1;
        in_data  = next_data;
      end
      out_ready = !(b == stall_beat && stall_left > 0);
      @(negedge clk);
      if (out_valid) begin
        if (!out_ready) begin
          chk("stall_hold_data", out_data, exp[b/N][b%N]);
          stall_left--;
        end else begin
          chk($sformatf("beat%0d_data", b), out_data, exp[b/N][b%N]);
          chk($sformatf("beat%0d_last", b), out_last, b == N*N-1);
          if (timed) chk($sformatf("beat%0d_edge", b), 256'(cyc - start_cyc), 256'(39 + b));
          if (hold_next) chk("in_ready_drain", in_ready, 1'b0);
          b++;
        end
      end
      @(posedge clk);
      #1;
      guard++;
    end
    out_ready = 1'b1;
    if (guard >= 300) chk("drain_timeout", 256'(b), 256'(N*N));
  endtask

  initial begin
    amat_t a0, id1, id2, ones;
    int    extra;
    a0   = mk_op(0);
    id1  = mk_op(1);
    id2  = mk_op(2);
    ones = mk_op(3);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mm_a", mm_a, '0);
    chk("rst_mm_b", mm_b, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Job 1: A=i+j, B=I, with junk on in_data while not ready
    load_mat(a0, 1'b0, 1'b1);
    load_mat(id1, 1'b0, 1'b0);
    @(negedge clk);
    chk("compute_busy", busy, 1'b1);
    chk("compute_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    repeat (4) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("mm_a_held", mm_a, a0);
    chk("mm_b_held", mm_b, id1);
    drain(mk_res(0), 1'b1, -1, 1'b0, '0);
    @(negedge clk);
    chk("post_in_ready", in_ready, 1'b1);
    chk("post_busy", busy, 1'b0);
    chk("post_out_valid", out_valid, 1'b0);

    // Job 2: all 0xFFFF, result wraps modulo 2^32
    @(posedge clk);
    #1;
    load_mat(ones, 1'b0, 1'b1);
    load_mat(ones, 1'b0, 1'b0);
    drain(mk_res(2), 1'b1, -1, 1'b0, '0);

    // Job 3: in_valid gaps during load, 3-cycle out_ready stall on beat 5
    load_mat(a0, 1'b1, 1'b1);
    load_mat(id1, 1'b1, 1'b0);
    drain(mk_res(0), 1'b0, 4, 1'b0, '0);
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("extra_beats", 256'(extra), '0);
    @(posedge clk);
    #1;

    // Job 4: reset while lat=3, then a fresh job
    load_mat(a0, 1'b0, 1'b1);
    load_mat(id1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_mm_a", mm_a, '0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_in_ready", in_ready, 1'b1);
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("abort_no_output", 256'(extra), '0);
    @(posedge clk);
    #1;
    load_mat(a0, 1'b0, 1'b1);
    load_mat(id2, 1'b0, 1'b0);
    drain(mk_res(1), 1'b1, -1, 1'b0, '0);

    // Jobs 5/6: back-to-back, next job's first beat pending during drain
    load_mat(a0, 1'b0, 1'b1);
    load_mat(id1, 1'b0, 1'b0);
    drain(mk_res(0), 1'b1, -1, 1'b1, a0[0][0]);
    load_mat(a0, 1'b0, 1'b1);
    load_mat(id2, 1'b0, 1'b0);
    drain(mk_res(1), 1'b1, -1, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Streaming front-end and sequencer for the N×N pipelined matrix multiplier. It accepts operands one element per beat over a valid/ready input stream: A row-major, then B row-major. It holds the operands in registers that drive the multiplier's A/B buses, and waits out the multiplier's fixed pipeline latency. It then snapshots C and returns it row-major over a valid/ready output stream, so one narrow-port host can share the wide combinational-array datapath.

## Interface
Parameters:
- N, 4, matrix dimension. Must match the multiplier instance.
- WIDTH, 16, operand element width. Result elements are 2*WIDTH.
- PIPE_STAGES, 5, multiplier pipeline depth. Must match the multiplier instance.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  sequencer can accept an input beat.
- in_data  in  WIDTH  operand element.
- mm_a  out  [WIDTH-1:0][N][N]  registered A operands to the multiplier.
- mm_b  out  [WIDTH-1:0][N][N]  registered B operands to the multiplier.
- mm_c  in  [2*WIDTH-1:0][N][N]  C result from the multiplier.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts a result beat.
- out_data  out  2*WIDTH  result element.
- out_last  out  1  marks the final element C[N-1][N-1].
- busy  out  1  high in COMPUTE or DRAIN.

## Operation
- States: LOAD_A, LOAD_B, COMPUTE, DRAIN. A single index counter `idx` (0..N*N-1) and a latency counter `lat` (0..PIPE_STAGES+1) drive all transitions.
- Handshakes:
  - Input beat: in_valid & in_ready at a rising edge.
  - Output beat: out_valid & out_ready at a rising edge.
- LOAD_A:
  - in_ready=1.
  - Each beat writes mm_a[idx/N][idx%N] = in_data and increments idx.
  - On the beat with idx=N*N-1: idx←0, go to LOAD_B.
- LOAD_B:
  - Same behaviour, writing mm_b.
  - On the last beat: idx←0, lat←0, go to COMPUTE.
- COMPUTE:
  - in_ready=0; mm_a and mm_b are held stable.
  - lat increments each cycle.
  - In the cycle with lat=PIPE_STAGES+1: capture all of mm_c into internal buffer c_buf, go to DRAIN.
- DRAIN:
  - out_valid=1.
  - out_data = c_buf[idx/N][idx%N], driven combinationally from state and idx.
  - out_last = (idx==N*N-1).
  - Each output beat increments idx. The beat with out_last=1 sets idx←0 and returns to LOAD_A.
- in_valid gaps in the load states and out_ready stalls in DRAIN both hold state; no counter advances.
- Data integrity:
  - in_data is ignored when in_ready=0.
  - out_data and out_last stay stable while out_valid & !out_ready.
- Arithmetic: the sequencer performs none. C is forwarded bit-exact from the snapshot, including any modulo-2^(2*WIDTH) wrap produced by the datapath.
- Reset:
  - Any state goes immediately to LOAD_A.
  - idx, lat, mm_a, mm_b and c_buf are cleared to 0.
  - A partially loaded or partially drained job is discarded; there is no resume.

## Timing
- Reset values:
  - in_ready=1 (state LOAD_A).
  - out_valid=0, out_data=0, out_last=0, busy=0.
  - mm_a and mm_b all 0.
- Load: minimum 2*N*N cycles with in_valid held high.
- Compute:
  - The last B beat at edge t updates mm_b at t.
  - The multiplier output mm_c is valid after edge t+PIPE_STAGES+1.
  - The snapshot is taken at edge t+PIPE_STAGES+2, which is also the DRAIN entry edge.
- Drain: out_valid rises the cycle after the snapshot edge. With out_ready high, N*N consecutive beats follow.
- N=4, PIPE_STAGES=5, no stalls, first input beat at edge 0:
  - Last B beat at edge 31.
  - DRAIN entered at edge 38.
  - Output beats at edges 39..54.
  - in_ready=1 again after edge 54.
- No overlap: the next job's A loading starts only after the out_last beat.

## Test plan
- A[i][j]=i+j, B=identity, continuous valid/ready -> 16 output beats 0,1,2,3,1,2,3,4,2,3,4,5,3,4,5,6 at edges 39..54; out_last only on the 16th beat; busy high over edges 32..54.
- All A and B elements 0xFFFF -> every out_data = 0xFFF80004 (4×0xFFFE0001 mod 2^32).
- in_valid toggled 1-0-1-0 during load; out_ready low for 3 cycles on beat 5 -> results identical to the identity case; out_data held constant across the stall; total beats exactly 16.
- Assert rst during COMPUTE (lat=3), then load a new job -> out_valid never rises for the aborted job; the new job's results are correct with the same cycle offsets measured from its first beat.
- Two back-to-back jobs (second with B=2×identity) -> the second job's output equals 2×A; in_ready stays 0 until the first job's out_last beat completes.
